multi_dispense_engine: RTL and testbench

Parametrised, multi-channel successor to the single-servo dispense controller. It accepts dispense requests over a valid/ready handshake, each request naming a channel and a repeat count. It runs the PUSH-REVERT-WAIT sequence on that channel's servo and LED, one channel at a time to respect the shared servo supply budget. Added over the previous generation: configurable channel count, count width and phase durations, abort, completion reporting, and bad-channel error reporting.

---
 rtl/multi_dispense_pkg.sv | 22 ++
 rtl/dispense_phase_timer.sv | 27 ++
 rtl/multi_dispense_engine.sv | 167 ++++++++++++++++
 tb/tb_multi_dispense_engine.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_dispense_pkg.sv
// Shared definitions for the multi-channel dispense engine.
//   state_t      : FSM state encoding (IDLE, PUSH, REVERT, WAIT)
//   ms_to_cycles : phase length in ms -> clock cycles
//   ch_width     : channel index width, never less than one bit
package multi_dispense_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PUSH   = 2'd1,
    REVERT = 2'd2,
    WAIT   = 2'd3
  } state_t;

  function automatic int ms_to_cycles(input int clk_freq, input int ms);
    return (clk_freq / 1000) * ms;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/dispense_phase_timer.sv
// Loadable down-counter timing one engine phase.
//   clk, rst_n : clock, async active-low reset
//   load       : reload the counter with load_val (takes priority)
//   load_val   : phase length minus one
//   tc         : terminal count, high while the counter sits at zero
// Loading N-1 on phase entry makes tc rise in the N-th cycle of the phase.
module dispense_phase_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - W'(1);
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/multi_dispense_engine.sv
// Multi-channel servo dispense engine. Runs PUSH-REVERT-WAIT on one
// channel at a time for a requested number of repeats.
//   clk, rst_n          : clock, async active-low reset
//   req_valid/req_ready : request handshake; req_ch, req_count payload
//   abort               : level, cuts the running job short (servo retracts)
//   servo_pos, led      : per-channel drive, only active_ch ever set
//   busy, active_ch     : job running / channel of current or last job
//   remaining           : pushes not yet completed
//   done, aborted       : completion pulse, aborted qualifies it
//   err                 : pulse when a request names a nonexistent channel
module multi_dispense_engine
  import multi_dispense_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 4,
  parameter int PUSH_MS   = 500,
  parameter int REVERT_MS = 500,
  parameter int WAIT_MS   = 500,
  localparam int CH_W     = ch_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CH_W-1:0]   req_ch,
  input  logic [CNT_W-1:0]  req_count,
  input  logic              abort,
  output logic [NUM_CH-1:0] servo_pos,
  output logic [NUM_CH-1:0] led,
  output logic              busy,
  output logic [CH_W-1:0]   active_ch,
  output logic [CNT_W-1:0]  remaining,
  output logic              done,
  output logic              aborted,
  output logic              err
);

  localparam int PUSH_CYC   = ms_to_cycles(CLK_FREQ, PUSH_MS);
  localparam int REVERT_CYC = ms_to_cycles(CLK_FREQ, REVERT_MS);
  localparam int WAIT_CYC   = ms_to_cycles(CLK_FREQ, WAIT_MS);
  localparam int MAX_CYC    = (PUSH_CYC > REVERT_CYC) ?
                              ((PUSH_CYC > WAIT_CYC) ? PUSH_CYC : WAIT_CYC) :
                              ((REVERT_CYC > WAIT_CYC) ? REVERT_CYC : WAIT_CYC);
  localparam int TMR_W      = $clog2(MAX_CYC) + 1;

  localparam logic [TMR_W-1:0] PUSH_LD   = TMR_W'(PUSH_CYC - 1);
  localparam logic [TMR_W-1:0] REVERT_LD = TMR_W'(REVERT_CYC - 1);
  localparam logic [TMR_W-1:0] WAIT_LD   = TMR_W'(WAIT_CYC - 1);
  localparam logic [CH_W:0]    NUM_CH_V  = (CH_W + 1)'(NUM_CH);

  state_t           state, state_nxt;
  logic             tmr_load, tc;
  logic [TMR_W-1:0] tmr_val;
  logic             done_nxt, abt_nxt, err_nxt;
  logic             abort_seen;
  logic             ch_bad, accept, start;

  assign ch_bad = ({1'b0, req_ch} >= NUM_CH_V);
  assign accept = req_valid && (state == IDLE);
  assign start  = accept && !ch_bad && (req_count != '0);

  dispense_phase_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Every state entry reloads the timer; an abort out of PUSH/WAIT counts
  // as a fresh REVERT entry.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    done_nxt  = 1'b0;
    abt_nxt   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (ch_bad)                err_nxt  = 1'b1;
          else if (req_count == '0)  done_nxt = 1'b1;
          else begin
            state_nxt = PUSH;
            tmr_load  = 1'b1;
            tmr_val   = PUSH_LD;
          end
        end
      end
      PUSH: begin
        if (abort || tc) begin
          state_nxt = REVERT;
          tmr_load  = 1'b1;
          tmr_val   = REVERT_LD;
        end
      end
      REVERT: begin
        if (tc) begin
          // An abort landing in the last REVERT cycle still ends the job.
          if (abort || remaining <= CNT_W'(1)) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
            abt_nxt   = abort || abort_seen;
          end else begin
            state_nxt = WAIT;
            tmr_load  = 1'b1;
            tmr_val   = WAIT_LD;
          end
        end
      end
      WAIT: begin
        if (abort) begin
          state_nxt = REVERT;
          tmr_load  = 1'b1;
          tmr_val   = REVERT_LD;
        end else if (tc) begin
          state_nxt = PUSH;
          tmr_load  = 1'b1;
          tmr_val   = PUSH_LD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_ch  <= '0;
      remaining  <= '0;
      abort_seen <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      err        <= 1'b0;
    end else begin
      done    <= done_nxt;
      aborted <= abt_nxt;
      err     <= err_nxt;
      if (start) begin
        active_ch  <= req_ch;
        remaining  <= req_count;
        abort_seen <= 1'b0;
      end else if (state != IDLE) begin
        if (abort) abort_seen <= 1'b1;
        if (state == REVERT && tc) remaining <= abort ? '0 : remaining - CNT_W'(1);
        else if (abort)            remaining <= CNT_W'(1);
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel;
    assign sel          = (active_ch == CH_W'(i));
    assign servo_pos[i] = sel && (state == PUSH);
    assign led[i]       = sel && (state == PUSH || state == REVERT);
  end

endmodule

// File: tb/tb_multi_dispense_engine.sv
// Directed bench for multi_dispense_engine with 4-cycle phases.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_dispense_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, abort, busy, done, aborted, err;
  logic [1:0] req_ch, active_ch;
  logic [3:0] req_count, remaining, servo_pos, led;

  logic       req_valid3, req_ready3, abort3, busy3, done3, aborted3, err3;
  logic [1:0] req_ch3, active_ch3;
  logic [3:0] req_count3, remaining3;
  logic [2:0] servo_pos3, led3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_dispense_engine #(
    .CLK_FREQ(1000), .NUM_CH(4), .CNT_W(4),
    .PUSH_MS(4), .REVERT_MS(4), .WAIT_MS(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ch(req_ch), .req_count(req_count), .abort(abort),
    .servo_pos(servo_pos), .led(led), .busy(busy), .active_ch(active_ch),
    .remaining(remaining), .done(done), .aborted(aborted), .err(err)
  );

  multi_dispense_engine #(
    .CLK_FREQ(1000), .NUM_CH(3), .CNT_W(4),
    .PUSH_MS(4), .REVERT_MS(4), .WAIT_MS(4)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_ch(req_ch3), .req_count(req_count3), .abort(abort3),
    .servo_pos(servo_pos3), .led(led3), .busy(busy3), .active_ch(active_ch3),
    .remaining(remaining3), .done(done3), .aborted(aborted3), .err(err3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_busy"},  32'(busy),      32'd0);
    chk({nm, "_servo"}, 32'(servo_pos), 32'd0);
    chk({nm, "_led"},   32'(led),       32'd0);
    chk({nm, "_ach"},   32'(active_ch), 32'd0);
    chk({nm, "_rem"},   32'(remaining), 32'd0);
    chk({nm, "_done"},  32'(done),      32'd0);
    chk({nm, "_abt"},   32'(aborted),   32'd0);
    chk({nm, "_err"},   32'(err),       32'd0);
  endtask

  // Issue one request; returns at the falling edge after the accepting edge.
  task automatic send(input logic [1:0] ch, input logic [3:0] cnt);
    @(negedge clk);
    req_valid = 1'b1; req_ch = ch; req_count = cnt;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  typedef struct {
    logic [1:0] ch;
    logic [3:0] cnt;
    int         total;     // cycles from PUSH start to done
    logic [3:0] onehot;    // expected channel drive
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{ch: 2'd2, cnt: 4'd3, total: 32, onehot: 4'b0100};
    vecs[1] = '{ch: 2'd0, cnt: 4'd1, total: 8,  onehot: 4'b0001};
    vecs[2] = '{ch: 2'd3, cnt: 4'd2, total: 20, onehot: 4'b1000};
    vecs[3] = '{ch: 2'd1, cnt: 4'd0, total: 0,  onehot: 4'b0000};

    rst_n = 1'b0; req_valid = 1'b0; req_ch = '0; req_count = '0; abort = 1'b0;
    req_valid3 = 1'b0; req_ch3 = '0; req_count3 = '0; abort3 = 1'b0;
    #2;
    chk_idle_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    // Job vectors: each 12-cycle period is 4 PUSH, 4 REVERT, 4 WAIT.
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].ch, vecs[v].cnt);
      for (int t = 0; t < vecs[v].total; t++) begin
        chk($sformatf("v%0d_servo_t%0d", v, t), 32'(servo_pos),
            32'(((t % 12) < 4) ? vecs[v].onehot : 4'b0000));
        chk($sformatf("v%0d_led_t%0d", v, t), 32'(led),
            32'(((t % 12) < 8) ? vecs[v].onehot : 4'b0000));
        chk($sformatf("v%0d_busy_t%0d", v, t), 32'(busy), 32'd1);
        chk($sformatf("v%0d_done_t%0d", v, t), 32'(done), 32'd0);
        if (t % 12 == 0)
          chk($sformatf("v%0d_rem_t%0d", v, t), 32'(remaining), 32'(vecs[v].cnt) - 32'(t / 12));
        @(negedge clk);
      end
      chk($sformatf("v%0d_done", v),  32'(done),      32'd1);
      chk($sformatf("v%0d_abt", v),   32'(aborted),   32'd0);
      chk($sformatf("v%0d_busy", v),  32'(busy),      32'd0);
      chk($sformatf("v%0d_ready", v), 32'(req_ready), 32'd1);
      chk($sformatf("v%0d_servo", v), 32'(servo_pos), 32'd0);
      chk($sformatf("v%0d_rem", v),   32'(remaining), 32'd0);
      @(negedge clk);
      chk($sformatf("v%0d_done_clr", v), 32'(done), 32'd0);
    end

    // Abort while idle does nothing.
    abort = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    chk("abort_idle_done", 32'(done), 32'd0);
    abort = 1'b0;

    // Bad channel on the 3-channel instance.
    @(negedge clk);
    req_valid3 = 1'b1; req_ch3 = 2'd3; req_count3 = 4'd2;
    @(negedge clk);
    req_valid3 = 1'b0;
    chk("err_pulse", 32'(err3),       32'd1);
    chk("err_servo", 32'(servo_pos3), 32'd0);
    chk("err_led",   32'(led3),       32'd0);
    chk("err_ready", 32'(req_ready3), 32'd1);
    chk("err_busy",  32'(busy3),      32'd0);
    chk("err_done",  32'(done3),      32'd0);
    chk("err_abt",   32'(aborted3),   32'd0);
    chk("err_rem",   32'(remaining3), 32'd0);
    chk("err_ach",   32'(active_ch3), 32'd0);
    @(negedge clk);
    chk("err_clr",   32'(err3),       32'd0);

    // Abort in the 2nd cycle of the 2nd PUSH of a 5-count job.
    send(2'd1, 4'd5);
    repeat (13) @(negedge clk);
    chk("abt_in_push", 32'(servo_pos), 32'b0010);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abt_rev_servo", 32'(servo_pos), 32'd0);
    chk("abt_rev_led",   32'(led),       32'b0010);
    chk("abt_rev_rem",   32'(remaining), 32'd1);
    chk("abt_rev_busy",  32'(busy),      32'd1);
    repeat (3) @(negedge clk);
    chk("abt_rev_end_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("abt_done",  32'(done),      32'd1);
    chk("abt_abt",   32'(aborted),   32'd1);
    chk("abt_rem",   32'(remaining), 32'd0);
    chk("abt_servo", 32'(servo_pos), 32'd0);
    chk("abt_busy",  32'(busy),      32'd0);
    @(negedge clk);
    chk("abt_clr", 32'(aborted), 32'd0);

    // Back-to-back: ch3 request held while ch0 runs is taken on the done cycle.
    send(2'd0, 4'd1);
    req_valid = 1'b1; req_ch = 2'd3; req_count = 4'd1;
    for (int t = 0; t < 8; t++) begin
      chk($sformatf("b2b_onehot_t%0d", t), 32'($countones(led) <= 1), 32'd1);
      chk($sformatf("b2b_ch0_t%0d", t), 32'(led & 4'b1110), 32'd0);
      @(negedge clk);
    end
    chk("b2b_done",  32'(done),      32'd1);
    chk("b2b_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_servo", 32'(servo_pos), 32'b1000);
    chk("b2b_ach",   32'(active_ch), 32'd3);
    chk("b2b_busy",  32'(busy),      32'd1);
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    chk("b2b_drain", 32'(busy), 32'd0);

    // Reset in the middle of WAIT.
    @(negedge clk);
    send(2'd2, 4'd3);
    repeat (9) @(negedge clk);
    chk("rst_in_wait_busy", 32'(busy), 32'd1);
    chk("rst_in_wait_led",  32'(led),  32'd0);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    begin
      logic seen_done;
      seen_done = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        seen_done |= done;
      end
      chk("midrst_no_done", 32'(seen_done), 32'd0);
      chk("midrst_idle",    32'(busy),      32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
